matrix_mem_ctrl: RTL
====================

// Module: matrix_mem_ctrl
// PURPOSE
//  Sequencer for the 4x4 group-addressed matrix_memory. Two jobs:
//  - LOAD: accept 4 groups from the host over a valid/ready stream and write them to addr 0..3.
//  - STREAM: play the 4 stored groups back, in order, to the compute array as a fixed-rate stream.
//  Sits between host/DMA and the memory. Sole driver of the memory's write and read ports.
// PARAMETERS
//  WIDTH   8   bits per matrix element
//  GROUPS  4   elements per group = groups per matrix; fixed at 4 (2-bit memory addr)
//  PERF_W  16  width of perf_cycles
// PORTS
//  clk            in   1              clock
//  rst            in   1              reset: synchronous, active-high
//  start_load     in   1              request LOAD; sampled in IDLE only
//  start_stream   in   1              request STREAM; sampled in IDLE only
//  in_valid       in   1              host group valid
//  in_ready       out  1              controller accepts group (comb: state==LOAD)
//  in_data        in   GROUPS*WIDTH   host group, element i at [i*WIDTH +: WIDTH]
//  mem_write_en   out  1              memory write enable (comb)
//  mem_write_addr out  2              memory write group addr (= cnt)
//  mem_data_in    out  GROUPS*WIDTH   memory write data (= in_data)
//  mem_read_en    out  1              memory read enable (comb: state==STREAM)
//  mem_read_addr  out  2              memory read group addr (= cnt)
//  mem_data_out   in   GROUPS*WIDTH   memory read data, valid 1 cycle after mem_read_en
//  out_valid      out  1              stream group valid (registered)
//  out_data       out  GROUPS*WIDTH   = mem_data_out while out_valid, else 0
//  out_last       out  1              marks group 3 of the stream (registered)
//  busy           out  1              state != IDLE
//  loaded         out  1              a complete matrix has been written since reset
//  done           out  1              1-cycle pulse at job end
//  perf_cycles    out  PERF_W         busy-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, and every registered output = 0 (out_valid, out_last, loaded, done, perf_cycles).
//  - States: IDLE, LOAD, STREAM, DRAIN. cnt is a 2-bit group counter.
//  - IDLE: start_load -> LOAD, cnt=0. Else start_stream && loaded -> STREAM, cnt=0.
//    start_load wins if both are asserted. start_stream with loaded=0 is ignored; no state change.
//  - LOAD: mem_write_en = in_valid. Each accept (in_valid && in_ready) writes addr cnt and increments cnt.
//    Host stalls (in_valid=0) are unbounded.
//    Accept at cnt==3 -> IDLE, loaded<=1, done pulse on the next cycle.
//  - STREAM: mem_read_en=1 for 4 consecutive cycles, addr 0,1,2,3. No backpressure.
//    out_valid<=mem_read_en. out_last<=(mem_read_en && cnt==3).
//    After addr 3 issues -> DRAIN (1 cycle) -> IDLE.
//  - Stream latency: start_stream sampled at edge E0; read addr0 issues in cycle after E0;
//    out_valid high for 4 cycles starting 2 cycles after E0; done asserted with out_last.
//  - start_* while busy: ignored; not queued.
//  - A LOAD over a loaded matrix overwrites groups as they arrive; loaded stays 1.
//  - Write and read are never issued in the same cycle.
//  - rst mid-LOAD or mid-STREAM: abort immediately, all outputs to reset values, loaded=0.
//    The memory is cleared by the same rst.
// CONFIGURATION
//  MATRIX_MEM_CTRL_PERF_EN defined:
//    - perf_cycles increments each cycle busy=1, saturates at all-ones, cleared only by rst.
//  MATRIX_MEM_CTRL_PERF_EN undefined:
//    - perf_cycles tied to 0; no counter logic. The port is present in both builds.
// STRUCTURE
//  - matrix_mem_pkg holds: ctrl state enum, MM_ADDR_W=2, MM_NUM_GROUPS=4, MM_LAST_ADDR=2'd3.
//  - One sub-module: matrix_mem_perf_cnt (saturating enable counter), instantiated only under the macro.
//  - Everything else is flat FSM + counter.
// TESTING
//  1. Load then stream, no stalls:
//     start_load, then groups 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles
//     -> 4 writes to addr 0..3, loaded=1, done pulse.
//     start_stream -> out_data in that order on 4 consecutive cycles; out_last on the 4th; done with it.
//  2. Host stalls: in_valid toggled 1,0,0,1,0,1,1 -> exactly 4 writes at addr 0..3 with correct data;
//     in_ready high throughout LOAD.
//  3. Stream before load: start_stream after rst -> busy stays 0, no mem_read_en, out_valid 0.
//  4. Simultaneous start_load and start_stream in IDLE with loaded=1 -> LOAD entered, no read issued.
//     start_load during STREAM -> ignored, stream completes 4 groups.
//  5. rst after 2 of 4 groups written -> state IDLE, loaded=0, done=0;
//     following start_stream ignored.
//  6. PERF_EN build: full load (4 cycles) + stream (5 cycles) -> perf_cycles=9.
//     Force near-max -> saturates at 0xFFFF.
//     Non-PERF build -> perf_cycles==0 always.

Source files
------------

// File: rtl/matrix_mem_pkg.sv
// Shared types and constants for the 4x4 group-addressed matrix memory sequencer.
// Optional busy-cycle counter in matrix_mem_ctrl is enabled by MATRIX_MEM_CTRL_PERF_EN.
package matrix_mem_pkg;

   localparam int                   MM_ADDR_W     = 2;
   localparam int                   MM_NUM_GROUPS = 4;
   localparam logic [MM_ADDR_W-1:0] MM_LAST_ADDR  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN
   } ctrl_state_e;

endpackage

// File: rtl/matrix_mem_perf_cnt.sv
// Saturating enable counter: counts cycles with en=1, holds at all-ones, cleared by rst.
// One-cycle latency from en to the count; no backpressure.
module matrix_mem_perf_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/matrix_mem_ctrl.sv
// LOAD/STREAM sequencer for matrix_memory; stream output 2 cycles after start, no stream backpressure.
// Host load side stalls freely via in_valid. Busy-cycle counter present only with MATRIX_MEM_CTRL_PERF_EN.
module matrix_mem_ctrl
   import matrix_mem_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int GROUPS = MM_NUM_GROUPS,
   parameter int PERF_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_load,
   input  logic                    start_stream,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [GROUPS*WIDTH-1:0] in_data,
   output logic                    mem_write_en,
   output logic [MM_ADDR_W-1:0]    mem_write_addr,
   output logic [GROUPS*WIDTH-1:0] mem_data_in,
   output logic                    mem_read_en,
   output logic [MM_ADDR_W-1:0]    mem_read_addr,
   input  logic [GROUPS*WIDTH-1:0] mem_data_out,
   output logic                    out_valid,
   output logic [GROUPS*WIDTH-1:0] out_data,
   output logic                    out_last,
   output logic                    busy,
   output logic                    loaded,
   output logic                    done,
   output logic [PERF_W-1:0]       perf_cycles
);

   ctrl_state_e          state_q, state_d;
   logic [MM_ADDR_W-1:0] cnt_q, cnt_d;
   logic                 loaded_q, loaded_d;
   logic                 done_q, done_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic                 accept;

   assign in_ready       = (state_q == ST_LOAD);
   assign accept         = in_valid && in_ready;
   assign mem_write_en   = accept;
   assign mem_write_addr = cnt_q;
   assign mem_data_in    = in_data;
   assign mem_read_en    = (state_q == ST_STREAM);
   assign mem_read_addr  = cnt_q;
   assign busy           = (state_q != ST_IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      loaded_d    = loaded_q;
      done_d      = 1'b0;
      out_valid_d = mem_read_en;
      out_last_d  = mem_read_en && (cnt_q == MM_LAST_ADDR);

      unique case (state_q)
         ST_IDLE: begin
            if (start_load) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end else if (start_stream && loaded_q) begin
               state_d = ST_STREAM;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + MM_ADDR_W'(1);
               if (cnt_q == MM_LAST_ADDR) begin
                  state_d  = ST_IDLE;
                  loaded_d = 1'b1;
                  done_d   = 1'b1;
               end
            end
         end
         ST_STREAM: begin
            cnt_d = cnt_q + MM_ADDR_W'(1);
            // done is registered, so it lines up with out_last of group 3
            if (cnt_q == MM_LAST_ADDR) begin
               state_d = ST_DRAIN;
               done_d  = 1'b1;
            end
         end
         ST_DRAIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         loaded_q    <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         loaded_q    <= loaded_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_valid_q ? mem_data_out : '0;
   assign loaded    = loaded_q;
   assign done      = done_q;

`ifdef MATRIX_MEM_CTRL_PERF_EN
   matrix_mem_perf_cnt #(
      .W (PERF_W)
   ) u_perf_cnt (
      .clk (clk),
      .rst (rst),
      .en  (busy),
      .cnt (perf_cycles)
   );
`else
   assign perf_cycles = '0;
`endif

endmodule
